// File: rtl/clk_test_unit.sv
// Retiming register stage: rotates data_in right by ROT_AMT, then delays it DEPTH clocks.
// Asynchronous active-low reset clears every stage.
module clk_test_unit #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 1,
  parameter int ROT_AMT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  if (WIDTH < 1) begin : g_bad_width
    $error("clk_test_unit: WIDTH must be >= 1");
  end
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("clk_test_unit: DEPTH must be in 1..8");
  end
  if (ROT_AMT < 0 || ROT_AMT > WIDTH - 1) begin : g_bad_rot
    $error("clk_test_unit: ROT_AMT must be in 0..WIDTH-1");
  end

  logic [WIDTH-1:0] rot_in;
  logic [WIDTH-1:0] pipe [DEPTH];

  // Rotation is pure wiring; the zero case avoids a full-width slice.
  if (ROT_AMT == 0) begin : g_no_rot
    assign rot_in = data_in;
  end else begin : g_rot
    assign rot_in = {data_in[ROT_AMT-1:0],
                     data_in[WIDTH-1:ROT_AMT]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= rot_in;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign data_out = pipe[DEPTH-1];

endmodule

// File: tb/tb_clk_test_unit.sv
// Scoreboard bench: three configurations of clk_test_unit driven by one stimulus
// stream and checked against an edge-indexed input log.
module tb_clk_test_unit;

  localparam int N = 3;
  localparam int DEP [N] = '{1, 3, 2};
  localparam int ROT [N] = '{0, 5, 1};

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [15:0] outs [N];

  int errors;
  int checks;
  int n;
  int rst_edge;
  logic [15:0] log_in [int];
  logic [15:0] expq [N][$];

  clk_test_unit #(.WIDTH(16), .DEPTH(1), .ROT_AMT(0)) u0 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(outs[0])
  );
  clk_test_unit #(.WIDTH(16), .DEPTH(3), .ROT_AMT(5)) u1 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(outs[1])
  );
  clk_test_unit #(.WIDTH(16), .DEPTH(2), .ROT_AMT(1)) u2 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(outs[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rot(input logic [15:0] x,
                                      input int a);
    logic [31:0] y;
    logic [31:0] r;
    y = {16'h0, x};
    r = (y >> a) | (y << (16 - a));
    return r[15:0];
  endfunction

  // Expected output after edge e: the word sampled DEPTH-1 edges earlier,
  // provided that edge came after the reset release.
  task automatic cycle(input logic [15:0] v);
    int m;
    logic [15:0] e;
    data_in = v;
    @(posedge clk);
    n++;
    if (rst && rst_edge < 0) rst_edge = n;
    log_in[n] = v;
    for (int k = 0; k < N; k++) begin
      m = n - DEP[k] + 1;
      if (rst && rst_edge >= 0 && m >= rst_edge)
        e = rot(log_in[m], ROT[k]);
      else
        e = 16'h0;
      expq[k].push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic [15:0] v, input int c);
    for (int i = 0; i < c; i++) cycle(v);
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b0;
    rst_edge = -1;
    for (int k = 0; k < N; k++) begin
      foreach (expq[k][i]) expq[k][i] = 16'h0;
    end
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (outs[k] !== 16'h0) begin
        errors++;
        $display("FAIL async_reset dut%0d got=%h exp=0000",
                 k, outs[k]);
      end
    end
  endtask

  task automatic release_reset();
    #2;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    for (int k = 0; k < N; k++) begin
      if (expq[k].size() > 0) begin
        e = expq[k].pop_front();
        checks++;
        if (outs[k] !== e) begin
          errors++;
          $display("FAIL data_out dut%0d t=%0t got=%h exp=%h",
                   k, $time, outs[k], e);
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    n = 0;
    rst_edge = -1;
    rst = 1'b0;
    data_in = 16'h5;
    hold(16'h5, 4);
    release_reset();
    hold(16'h5, 4);
    hold(16'h0, 3);
    hold(16'h1, 3);
    hold(16'hC, 3);
    hold(16'h5, 3);
    cycle(16'hFFFF);
    hold(16'h0000, 4);
    hold(16'h0003, 4);
    hold(16'h0002, 4);
    cycle(16'h1);
    cycle(16'h2);
    cycle(16'h3);
    mid_reset();
    hold(16'h3, 2);
    release_reset();
    hold(16'h7, 5);
    for (int i = 0; i < 300; i++) begin
      cycle(16'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        mid_reset();
        hold(16'($urandom), $urandom_range(1, 3));
        release_reset();
      end
    end
    @(negedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (expq[k].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d got=%0d exp=0",
                 k, expq[k].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
